// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed divider using a non-restoring shift/subtract
// core over operand magnitudes, followed by a sign fix-up step.
//
// Ports:
//   clk          rising-edge clock
//   clr          synchronous active-high reset (aborts any divide in flight)
//   start        begin a divide; only sampled while idle
//   dividend     signed dividend, captured on accept
//   divisor      signed divisor, captured on accept
//   busy         high whenever the FSM is not idle
//   done         one-cycle pulse when results are valid
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, carries the sign of the dividend
//   div_by_zero  the last accepted divisor was zero
//
// Timing for an accept in cycle T:
//   nonzero divisor -> RUN T+1..T+WIDTH, FIX T+WIDTH+1, DONE T+WIDTH+2
//   zero divisor    -> DONE at T+1
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t         state, state_nx;
    logic [WIDTH:0] acc;       // partial remainder, one extra bit for sign
    logic [WIDTH-1:0] q_reg;   // quotient magnitude being built
    logic [WIDTH-1:0] m_reg;   // divisor magnitude
    logic           q_neg;
    logic           r_neg;
    logic [CW-1:0]  cnt;

    logic [WIDTH:0]   acc_sh, acc_step, acc_fix;
    logic [WIDTH-1:0] q_fin, r_fin;
    logic [WIDTH-1:0] dividend_abs, divisor_abs;

    // Magnitudes are unsigned WIDTH-bit values, so -2^(WIDTH-1) maps to
    // 2^(WIDTH-1) without overflow.
    assign dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;

    // One non-restoring step: shift {acc,q} left, then add or subtract the
    // divisor depending on the sign of the partial remainder before the shift.
    assign acc_sh   = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
    assign acc_step = acc[WIDTH] ? (acc_sh + {1'b0, m_reg})
                                 : (acc_sh - {1'b0, m_reg});

    // A negative final partial remainder needs one restore.
    assign acc_fix = acc[WIDTH] ? (acc + {1'b0, m_reg}) : acc;
    assign q_fin   = q_neg ? -q_reg : q_reg;
    assign r_fin   = r_neg ? -acc_fix[WIDTH-1:0] : acc_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE: if (start) state_nx = (divisor == '0) ? DONE : RUN;
            RUN:  if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            acc         <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        q_reg <= dividend_abs;
                        m_reg <= divisor_abs;
                        q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg <= dividend[WIDTH-1];
                        cnt   <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    q_reg <= {q_reg[WIDTH-2:0], ~acc_step[WIDTH]};
                    cnt   <= cnt + CW'(1);
                end
                FIX: begin
                    quotient  <= q_fin;
                    remainder <= r_fin;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] dividend, divisor;
    logic        busy, done;
    logic [31:0] quotient, remainder;
    logic        div_by_zero;

    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          t;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                check("latency", cyc - e.t, e.lat);
            end
        end
    end

    // Present one start for one cycle; operands are scrambled afterwards.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit expect_res,
                         input logic [31:0] q, input logic [31:0] r, input bit dbz, input int lat);
        exp_t e;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        if (expect_res) begin
            e.q = q; e.r = r; e.dbz = dbz; e.t = cyc; e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
        end
    endtask

    task automatic div(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input bit dbz, input string name);
        issue(a, b, 1'b1, q, r, dbz, (b == 0) ? 1 : 34);
        wait_done(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        clr = 1'b0;

        // Back-to-back: each issue starts in the idle cycle right after done.
        div(32'd100,  32'd7,          32'd14,         32'd2,          1'b0, "p100_7");
        div(-32'd100, 32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, "m100_7");
        div(32'd100,  -32'd7,         32'hFFFFFFF2,   32'd2,          1'b0, "p100_m7");
        div(-32'd7,   -32'd2,         32'd3,          32'hFFFFFFFF,   1'b0, "m7_m2");
        div(32'd5,    32'd7,          32'd0,          32'd5,          1'b0, "p5_7");
        div(32'd100,  32'd0,          32'hFFFFFFFF,   32'd100,        1'b1, "p100_0");
        div(32'd9,    32'd3,          32'd3,          32'd0,          1'b0, "p9_3");
        div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,          1'b0, "min_m1");
        div(32'h80000000, 32'd1,      32'h80000000,   32'd0,          1'b0, "min_1");
        div(32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF,   1'b0, "max_min");

        // Abort: clr ten cycles into a divide; no done may follow.
        issue(32'd1000, 32'd3, 1'b0, '0, '0, 1'b0, 0);
        repeat (9) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (40) @(negedge clk);
        div(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, "p1000_3");

        // Start pulsed mid-divide with other operands must be ignored.
        issue(32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0, 34);
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 32'd7; divisor = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("p50_5");

        // Outputs hold after done.
        repeat (5) @(negedge clk);
        check("hold_quotient", quotient, 32'd10);
        check("hold_busy", {31'd0, busy}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-003 SHALL have port clr, input, 1, meaning reset; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, meaning a request to begin a divide, sampled only in IDLE.
REQ-005 SHALL have port dividend, input, WIDTH, meaning the signed two's-complement dividend, sampled on accept.
REQ-006 SHALL have port divisor, input, WIDTH, meaning the signed two's-complement divisor, sampled on accept.
REQ-007 SHALL have port busy, output, 1, meaning high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1, meaning a one-cycle pulse when results are valid.
REQ-009 SHALL have port quotient, output, WIDTH, meaning the signed quotient (LO destination).
REQ-010 SHALL have port remainder, output, WIDTH, meaning the signed remainder (HI destination).
REQ-011 SHALL have port div_by_zero, output, 1, meaning the last accepted divisor was zero.

Function
REQ-012 SHALL implement states IDLE, RUN, FIX, DONE.
REQ-013 SHALL accept in IDLE when start=1 (cycle T): latch |dividend| into Q, |divisor| into M, A=0 (WIDTH+1 bits), record sign flags, step counter=0.
REQ-014 SHALL on accept with divisor=0 go directly to DONE without entering RUN.
REQ-015 SHALL on accept with divisor!=0 enter RUN; RUN lasts exactly WIDTH cycles (T+1..T+WIDTH).
REQ-016 SHALL per RUN cycle perform one non-restoring step: shift {A,Q} left 1; if old A>=0 then A=A-M, else A=A+M; Q[0]=~A[WIDTH] (new sign).
REQ-017 SHALL enter FIX at T+WIDTH+1: if A<0 then A=A+M; quotient=neg(Q) if dividend and divisor signs differ, else Q; remainder=neg(A[WIDTH-1:0]) if dividend negative, else A.
REQ-018 SHALL in DONE assert done=1 for exactly one cycle (T+WIDTH+2 for nonzero divisor, T+1 for zero divisor), then return to IDLE.
REQ-019 SHALL on divide-by-zero drive quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
REQ-020 SHALL clear div_by_zero on every accepted start with a nonzero divisor.
REQ-021 SHALL compute -2^(WIDTH-1) / -1 with wrap: quotient=0x80000000 (WIDTH=32), remainder=0, no error flag.
REQ-022 SHALL truncate toward zero; remainder sign equals dividend sign or remainder is zero.
REQ-023 SHALL hold quotient, remainder, div_by_zero stable from DONE until the next accepted start.
REQ-024 SHALL ignore start while busy=1; operand inputs SHALL be ignored outside the accept cycle.
REQ-025 SHALL accept a new start in the IDLE cycle immediately following DONE (back-to-back throughput WIDTH+3 cycles).

Reset
REQ-026 SHALL on clr=1 at a clock edge set state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-027 SHALL give clr priority over start and over any in-progress operation; an aborted divide produces no done pulse.

Verification
REQ-028 SHALL test 100 / 7 -> done at T+34, quotient=14, remainder=2, div_by_zero=0.
REQ-029 SHALL test -100 / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); and 100 / -7 -> quotient=-14, remainder=2.
REQ-030 SHALL test 100 / 0 -> done at T+1, quotient=0xFFFFFFFF, remainder=100, div_by_zero=1; then 9 / 3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-031 SHALL test 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; and 0x80000000 / 1 -> quotient=0x80000000, remainder=0.
REQ-032 SHALL test clr at T+10 of a 1000/3 divide -> next cycle busy=0, outputs 0, no done pulse; new start then completes with quotient=333, remainder=1.
REQ-033 SHALL test start pulsed with different operands at T+5 of 50/5 -> ignored; result quotient=10, remainder=0 at T+34.
